// File: rtl/bias_add_if.sv
// Stream and bias-buffer bundle for the bias-add stage.
// slave = the bias_add side, master = the upstream/downstream/buffer side.
interface bias_add_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              bias_read_buffer_a_en;
  logic [ADDR_W-1:0] bias_read_buffer_a_addr;
  logic [DATA_W-1:0] bias_read_buffer_a_data;

  modport slave (
    input  in_valid, in_data, out_ready, bias_read_buffer_a_data,
    output in_ready, out_valid, out_data, bias_read_buffer_a_en, bias_read_buffer_a_addr
  );

  modport master (
    output in_valid, in_data, out_ready, bias_read_buffer_a_data,
    input  in_ready, out_valid, out_data, bias_read_buffer_a_en, bias_read_buffer_a_addr
  );
endinterface

// File: rtl/bias_add.sv
// Bias-add stage: adds a per-channel bias word (read from the bias buffer)
// to each 512-bit feature beat, optional ReLU, two-register pipeline.
module bias_add #(
  parameter int BIAS_INST_BIT_WIDTH = 128,
  parameter int C_M_AXI_DATA_WIDTH  = 512,
  parameter int C_ADDER_BIT_WIDTH   = 32,
  parameter int C_BUF_ADDR_WIDTH    = 9
) (
  input  logic                           kernel_clk,
  input  logic                           kernel_rst,
  input  logic                           ap_start,
  output logic                           ap_done,
  input  logic [BIAS_INST_BIT_WIDTH-1:0] ctrl_instruction,
  bias_add_if.slave                      s
);
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int W     = C_ADDER_BIT_WIDTH;
  localparam int AW    = C_BUF_ADDR_WIDTH;
  localparam int LANES = DW / W;

  typedef enum logic [2:0] {IDLE, DECODE, RUN, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [BIAS_INST_BIT_WIDTH-1:0] inst_q;
  logic [AW-1:0]                base_q, addr_q, addr_d;
  logic [15:0]                  k_q, k_eff, j_q;
  logic                         relu_q;
  logic [31:0]                  total_q, acc_cnt_q;
  logic                         s1_vld_q, s1_vld_d, s1_first_q;
  logic [DW-1:0]                s1_data_q, bias_hold_q, bias_use, res;
  logic                         s2_vld_q, s2_vld_d;
  logic [DW-1:0]                s2_data_q;
  logic                         in_fire, s1_adv;
  logic                         unused_ok;

  // Instruction bits this stage does not look at.
  assign unused_ok = ^{inst_q[31:0], inst_q[47:32+AW], inst_q[BIAS_INST_BIT_WIDTH-1:81]};

  assign k_eff    = (inst_q[79:64] == 16'd0) ? 16'd1 : inst_q[79:64];
  assign s1_adv   = s1_vld_q & (~s2_vld_q | s.out_ready);
  assign s.in_ready = (state_q == RUN) & (acc_cnt_q < total_q) & (~s1_vld_q | s1_adv);
  assign in_fire  = s.in_valid & s.in_ready;

  // Bias read issued in the acceptance cycle; address holds when idle.
  assign addr_d                    = in_fire ? (base_q + j_q[AW-1:0]) : addr_q;
  assign s.bias_read_buffer_a_en   = in_fire;
  assign s.bias_read_buffer_a_addr = addr_d;

  // Live buffer data only in the cycle right after the read; later the held copy.
  assign bias_use = s1_first_q ? s.bias_read_buffer_a_data : bias_hold_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] sum;
    assign sum = s1_data_q[i*W +: W] + bias_use[i*W +: W];
    assign res[i*W +: W] = (relu_q && sum[W-1]) ? '0 : sum;
  end

  assign s1_vld_d = in_fire | (s1_vld_q & ~s1_adv);
  assign s2_vld_d = s1_adv | (s2_vld_q & ~s.out_ready);

  assign s.out_valid = s2_vld_q;
  assign s.out_data  = s2_data_q;
  assign ap_done     = (state_q == DONE);

  // Next-state: DRAIN ends on the edge where the last beat leaves S2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ap_start) state_d = DECODE;
      DECODE:  state_d = (inst_q[63:48] == 16'd0) ? DONE : RUN;
      RUN:     if (acc_cnt_q == total_q) state_d = DRAIN;
      DRAIN:   if (!s1_vld_d && !s2_vld_d) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Instruction capture, field decode and beat/row counters.
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      inst_q    <= '0;
      base_q    <= '0;
      k_q       <= '0;
      relu_q    <= 1'b0;
      total_q   <= '0;
      acc_cnt_q <= '0;
      j_q       <= '0;
      addr_q    <= '0;
    end else begin
      addr_q <= addr_d;
      if (state_q == IDLE && ap_start) inst_q <= ctrl_instruction;
      if (state_q == DECODE) begin
        base_q    <= inst_q[32 +: AW];
        k_q       <= k_eff;
        relu_q    <= inst_q[80];
        total_q   <= 32'(inst_q[63:48]) * 32'(k_eff);
        acc_cnt_q <= '0;
        j_q       <= '0;
      end else if (in_fire) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
        j_q       <= (j_q == k_q - 16'd1) ? 16'd0 : j_q + 16'd1;
      end
    end
  end

  // S1 (beat + bias hold) and S2 (output register).
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_data_q   <= '0;
      bias_hold_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_data_q   <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= in_fire;
      if (in_fire)    s1_data_q   <= s.in_data;
      if (s1_first_q) bias_hold_q <= s.bias_read_buffer_a_data;
      s2_vld_q <= s2_vld_d;
      if (s1_adv)     s2_data_q   <= res;
    end
  end
endmodule

// File: tb/tb_bias_add.sv
// Directed bench for bias_add: scoreboard queue filled by stimulus,
// drained by a negedge monitor.
module tb_bias_add;
  localparam int DW = 512;
  localparam int AW = 9;
  localparam int IW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          ap_start;
  logic          ap_done;
  logic [IW-1:0] inst;

  bias_add_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  bias_add #(
    .BIAS_INST_BIT_WIDTH(IW), .C_M_AXI_DATA_WIDTH(DW),
    .C_ADDER_BIT_WIDTH(32), .C_BUF_ADDR_WIDTH(AW)
  ) dut (
    .kernel_clk(clk), .kernel_rst(rst), .ap_start(ap_start),
    .ap_done(ap_done), .ctrl_instruction(inst), .s(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bias_mem [0:511];
  // Buffer model: data valid one cycle after en, junk otherwise.
  always @(posedge clk)
    bus.bias_read_buffer_a_data <= bus.bias_read_buffer_a_en ?
      bias_mem[bus.bias_read_buffer_a_addr] : {16{32'hDEADBEEF}};

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, hs_cnt = 0, last_hs_cyc = 0, en_cnt = 0, ir_cnt = 0;
  bit saw_ir_low = 0, prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] sb_q[$];
  logic [AW-1:0] addr_q[$];

  function automatic logic [DW-1:0] fill(input logic [31:0] v);
    return {16{v}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: read addresses, output handshakes, stall stability, done pulses.
  initial forever begin
    @(negedge clk);
    if (rst) prev_stall = 0;
    else begin
      if (ap_done) begin done_cnt++; done_cyc = cyc; end
      if (bus.in_ready) ir_cnt++;
      if (bus.bias_read_buffer_a_en) begin
        en_cnt++;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_addr: unexpected read at %0d", bus.bias_read_buffer_a_addr);
        end else chk("rd_addr", DW'(bus.bias_read_buffer_a_addr), DW'(addr_q.pop_front()));
      end
      if (prev_stall && bus.out_valid) chk("stall_hold", bus.out_data, prev_data);
      if (bus.out_valid && !bus.out_ready && bus.in_valid && !bus.in_ready) saw_ir_low = 1;
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++; last_hs_cyc = cyc;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_data: unexpected beat %h", bus.out_data);
        end else chk("out_data", bus.out_data, sb_q.pop_front());
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // All tasks are entered and left just after a rising edge.
  task automatic start_instr(input logic [15:0] base, n, k, input bit relu);
    inst = '0;
    inst[47:32] = base; inst[63:48] = n; inst[79:64] = k; inst[80] = relu;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] exp, input logic [AW-1:0] a);
    bit hs = 0;
    sb_q.push_back(exp);
    addr_q.push_back(a);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk); #1;
      if (hs) break;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL in_handshake: timeout got 0 want 1");
    end
  endtask

  task automatic wait_done(input string name);
    int s0 = done_cnt;
    bit ok = 0;
    bus.in_valid = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #1;
      if (done_cnt > s0) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_done: timeout got 0 want 1", name);
    end
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_done_once"}, DW'(done_cnt - s0), DW'(1));
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_out_valid"}, DW'(bus.out_valid), '0);
    chk({name, "_in_ready"},  DW'(bus.in_ready), '0);
    chk({name, "_ap_done"},   DW'(ap_done), '0);
    chk({name, "_en"},        DW'(bus.bias_read_buffer_a_en), '0);
    chk({name, "_addr"},      DW'(bus.bias_read_buffer_a_addr), '0);
    chk({name, "_out_data"},  bus.out_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d, e;
    int s0, e0, i0, h0;
    for (int i = 0; i < 512; i++) bias_mem[i] = '0;
    rst = 1'b1; ap_start = 1'b0; inst = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-beat rows, relu off.
    bias_mem[5] = fill(32'd10);
    start_instr(16'd5, 16'd3, 16'd1, 1'b0);
    send(fill(32'd1), fill(32'd11), 9'd5);
    send(fill(32'd2), fill(32'd12), 9'd5);
    send(fill(32'd3), fill(32'd13), 9'd5);
    wait_done("t1");
    chk("t1_done_lat", DW'(done_cyc - last_hs_cyc), DW'(1));

    // Multi-beat rows, plus an ap_start while busy.
    bias_mem[0] = fill(32'd1);
    bias_mem[1] = fill(32'd100);
    start_instr(16'd0, 16'd2, 16'd2, 1'b0);
    @(posedge clk); #1;
    inst = '0; ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    send('0, fill(32'd1),   9'd0);
    send('0, fill(32'd100), 9'd1);
    send('0, fill(32'd1),   9'd0);
    send('0, fill(32'd100), 9'd1);
    wait_done("t2");

    // ReLU and wrap.
    bias_mem[7] = '0;
    bias_mem[7][31:0] = 32'd5; bias_mem[7][63:32] = 32'd1;
    d = '0; d[31:0] = 32'hFFFFFFEC; d[63:32] = 32'h7FFFFFFF;
    start_instr(16'd7, 16'd1, 16'd1, 1'b1);
    send(d, '0, 9'd7);
    wait_done("t3a");
    e = '0; e[31:0] = 32'hFFFFFFF1; e[63:32] = 32'h80000000;
    start_instr(16'd7, 16'd1, 16'd1, 1'b0);
    send(d, e, 9'd7);
    wait_done("t3b");

    // Backpressure: out_ready low for 5 cycles after the 2nd output.
    bias_mem[20] = fill(32'd3);
    h0 = hs_cnt; saw_ir_low = 0;
    start_instr(16'd20, 16'd6, 16'd1, 1'b0);
    fork
      begin
        send(fill(32'd1),  fill(32'd4),  9'd20);
        send(fill(32'd11), fill(32'd14), 9'd20);
        send(fill(32'd21), fill(32'd24), 9'd20);
        send(fill(32'd31), fill(32'd34), 9'd20);
        send(fill(32'd41), fill(32'd44), 9'd20);
        send(fill(32'd51), fill(32'd54), 9'd20);
        bus.in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk); #1;
          if (hs_cnt >= h0 + 2) break;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done("t4");
    chk("t4_in_ready_dropped", DW'(saw_ir_low), DW'(1));
    chk("t4_beats", DW'(hs_cnt - h0), DW'(6));

    // Zero rows: no reads, no in_ready, done two cycles after start.
    e0 = en_cnt; i0 = ir_cnt; s0 = cyc;
    start_instr(16'd3, 16'd0, 16'd4, 1'b0);
    wait_done("t5");
    chk("t5_done_lat", DW'(done_cyc - s0), DW'(2));
    chk("t5_no_reads", DW'(en_cnt - e0), '0);
    chk("t5_no_in_ready", DW'(ir_cnt - i0), '0);

    // Reset mid-RUN after 2 of 4 beats, then a fresh instruction.
    bias_mem[30] = fill(32'd7);
    start_instr(16'd30, 16'd4, 16'd1, 1'b0);
    send(fill(32'd1), fill(32'd8), 9'd30);
    send(fill(32'd2), fill(32'd9), 9'd30);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    sb_q.delete();
    addr_q.delete();
    s0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", DW'(done_cnt - s0), '0);
    start_instr(16'd30, 16'd2, 16'd1, 1'b1);
    send(fill(32'd5),          fill(32'd12), 9'd30);
    send(fill(32'hFFFFFFF0),   '0,           9'd30);
    wait_done("t6");

    chk("sb_empty", DW'(sb_q.size()), '0);
    chk("rd_q_empty", DW'(addr_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bias_add.md
Name: bias_add

Overview:
- Bias-add stage directly downstream of the bias loader.
- Streams 512-bit feature beats, typically aggregation/combination results, and adds a per-channel bias vector to each beat.
- The bias vector is read from the bias buffer port A; the loader filled that buffer through port B.
- Optional ReLU is applied; results are emitted on an AXI4-Stream-style output to the next stage (writeback/output buffer).
- Driven by the ctrl module via ap_start/ap_done and a 128-bit instruction.

Parameters:
- BIAS_INST_BIT_WIDTH, 128, instruction width.
- C_M_AXI_DATA_WIDTH, 512, beat width.
- C_ADDER_BIT_WIDTH, 32, lane width. LANES = C_M_AXI_DATA_WIDTH / C_ADDER_BIT_WIDTH = 16.
- C_BUF_ADDR_WIDTH, 9, bias buffer address width (depth 512).

Ports:
- kernel_clk  in  1  sole clock.
- kernel_rst  in  1  asynchronous, active-high reset.
- ap_start  in  1  one-cycle start pulse; ignored unless IDLE.
- ap_done  out  1  one-cycle pulse when the instruction completes.
- ctrl_instruction  in  BIAS_INST_BIT_WIDTH  sampled on accepted ap_start.
- bias_read_buffer_a_en  out  1  bias buffer read enable.
- bias_read_buffer_a_addr  out  C_BUF_ADDR_WIDTH  bias buffer read address.
- bias_read_buffer_a_data  in  C_M_AXI_DATA_WIDTH  read data, valid exactly 1 cycle after en.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat ready.
- in_data  in  C_M_AXI_DATA_WIDTH  input beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  output beat ready.
- out_data  out  C_M_AXI_DATA_WIDTH  output beat.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-operation aborts the instruction; in-flight beats are discarded, and no ap_done is issued.
- Instruction fields:
  - [47:32] bias base address; low C_BUF_ADDR_WIDTH bits used.
  - [63:48] row count N.
  - [79:64] beats per row K; K=0 is treated as 1.
  - [80] relu_en.
  - Total beats = N*K, tracked in a 32-bit counter.
- State flow: IDLE -> DECODE (1 cycle, latch fields) -> RUN -> DRAIN -> DONE (ap_done=1 for exactly 1 cycle) -> IDLE.
- N=0: DECODE goes straight to DONE. ap_done pulses 2 cycles after ap_start, with no buffer reads and in_ready never asserted.
- Handshakes: a transfer occurs when valid&ready are high at the clock edge. out_valid and out_data stay stable until accepted. in_ready is low outside RUN.
- Pipeline:
  - Stage S1 holds the accepted input beat and its bias.
  - Stage S2 is the output register.
  - in_ready = RUN & beats_accepted<N*K & (S1 empty | S1 advancing this cycle).
  - S1 advances into S2 when S2 is empty or out_ready is high.
- Bias read:
  - On every input acceptance, en=1 and addr = base + j (mod 2^C_BUF_ADDR_WIDTH). j is the beat index within the row; it counts 0..K-1 and wraps to 0 at row end.
  - en=0 on all other cycles; addr holds its last value.
  - The cycle after the read, S1 captures bias_read_buffer_a_data into a bias hold register.
  - S1's sum uses the live buffer data in that first cycle and the hold register thereafter, so a stall never depends on the buffer holding its output.
- Arithmetic, per lane i: sum = in lane i + bias lane i, modulo 2^C_ADDER_BIT_WIDTH; two's complement wrap, no saturation.
- ReLU: if relu_en and the sum MSB is 1, the lane becomes 0.
- Latency: input acceptance to out_valid is 2 cycles with no backpressure. Throughput is 1 beat/cycle.
- RUN -> DRAIN once N*K beats are accepted. DRAIN -> DONE on the cycle after the last output handshake, i.e. S1 and S2 are empty.
- A simultaneous S2 drain and S1 refill in the same cycle is legal and must not drop or duplicate a beat.

Test Plan:
- Single-beat rows, relu off: base=5, K=1, N=3, bias lanes all 10; inputs with lanes all 1, 2, 3 -> outputs lanes 11, 12, 13; reads at addr 5 three times; ap_done pulses once, 1 cycle after the 3rd output handshake.
- Multi-beat rows: base=0, K=2, N=2; bias word0 lanes=1, word1 lanes=100; 4 zero inputs -> outputs 1, 100, 1, 100; read addrs 0, 1, 0, 1.
- ReLU and wrap:
  - Lane0 in=0xFFFFFFEC, bias=5 -> 0 with relu_en=1, 0xFFFFFFF1 with relu_en=0.
  - Lane1 in=0x7FFFFFFF, bias=1 -> 0 with relu_en=1, 0x80000000 with relu_en=0.
- Backpressure: N=6, K=1, out_ready low for 5 cycles after the 2nd output -> out_data stable, in_ready drops, all 6 results correct and in order, and the bias stays correct across the stall.
- Zero rows and busy start: N=0 -> no en pulses, ap_done 2 cycles after ap_start. A second ap_start issued during RUN is ignored.
- Reset mid-RUN: assert kernel_rst after 2 of 4 beats -> all outputs 0 immediately and no ap_done; a fresh instruction afterwards completes correctly.
